cache_controller: RTL and testbench

- Sequencing FSM that sits between the trace/command front end and the set-associative L1 `cache` array.
- For each accepted command it does the following:
  - reads the addressed set;
  - performs tag compare and victim selection;
  - computes the new LRU and MESI state of all ways;
  - writes the set back;
  - reports hit/miss/writeback status and keeps running statistics.
- The cache array itself stays a storage block. All replacement and coherence policy lives here.

---
 rtl/cache_controller_pkg.sv | 65 ++++++
 rtl/cache_controller_lru.sv | 25 ++
 rtl/cache_controller.sv | 228 ++++++++++++++++++++++
 tb/tb_cache_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_controller_pkg.sv
// Shared types for the L1 cache controller: address/command layout,
// cache line format, MESI encoding and controller state.
package cache_controller_pkg;

   localparam int SETS     = 16384;
   localparam int WAYS     = 8;
   localparam int INDEX_W  = $clog2(SETS);
   localparam int LRU_W    = $clog2(WAYS);
   localparam int OFFSET_W = 6;
   localparam int ADDR_W   = 32;
   localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
   localparam int DATA_W   = 32;

   localparam logic [3:0] CMD_READ    = 4'd0;
   localparam logic [3:0] CMD_WRITE   = 4'd1;
   localparam logic [3:0] CMD_IFETCH  = 4'd2;
   localparam logic [3:0] CMD_SNP_INV = 4'd3;
   localparam logic [3:0] CMD_SNP_RD  = 4'd4;
   localparam logic [3:0] CMD_RESET   = 4'd8;
   localparam logic [3:0] CMD_PRINT   = 4'd9;

   typedef enum logic [1:0] {
      MESI_I = 2'd0,
      MESI_S = 2'd1,
      MESI_E = 2'd2,
      MESI_M = 2'd3
   } mesi_t;

   typedef struct packed {
      logic [TAG_W-1:0]    tag;
      logic [INDEX_W-1:0]  set_index;
      logic [OFFSET_W-1:0] offset;
   } address_t;

   typedef struct packed {
      logic [3:0] n;
      address_t   address;
   } command_t;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      mesi_t             mesi;
      logic [LRU_W-1:0]  lru;
      logic [DATA_W-1:0] data;
   } cache_line_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_CMP,
      ST_WR,
      ST_DONE
   } ctrl_state_t;

   // Commands that read, compare and write back a set
   function automatic logic uses_cmp(input logic [3:0] n);
      return n <= CMD_SNP_RD;
   endfunction

   // Commands that touch LRU and the hit/miss statistics
   function automatic logic is_access(input logic [3:0] n);
      return n == CMD_READ || n == CMD_WRITE || n == CMD_IFETCH;
   endfunction

endpackage

// File: rtl/cache_controller_lru.sv
// True-LRU age update for one set: accessed way becomes 0 (MRU),
// ways younger than it age by one, older ways keep their age.
module lru_update #(
   parameter int ways = 8,
   parameter int LW   = $clog2(ways)
) (
   input  logic [ways-1:0][LW-1:0] lru,
   input  logic [LW-1:0]           way,
   output logic [ways-1:0][LW-1:0] lru_next
);

   logic [LW-1:0] pivot;

   always_comb begin
      lru_next = lru;
      pivot    = lru[way];
      for (int i = 0; i < ways; i++) begin
         if (i == int'(way))
            lru_next[i] = '0;
         else if (lru[i] < pivot)
            lru_next[i] = lru[i] + 1'b1;
      end
   end

endmodule

// File: rtl/cache_controller.sv
// Sequencing FSM for the set-associative L1: read set, tag compare,
// LRU/MESI update, write back, status and statistics.
module cache_controller
   import cache_controller_pkg::*;
#(
   parameter int sets  = SETS,
   parameter int ways  = WAYS,
   parameter int CNT_W = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  command_t                     cmd,
   output command_t                     instruction,
   output logic                         read_enable,
   output logic                         write_enable,
   input  cache_line_t [ways-1:0]       cache_rd,
   output cache_line_t [ways-1:0]       cache_wr,
   output logic                         done,
   output logic                         hit,
   output logic                         writeback,
   output logic [$clog2(ways)-1:0]      way_out,
   output logic [CNT_W-1:0]             hit_count,
   output logic [CNT_W-1:0]             miss_count,
   output logic [CNT_W-1:0]             read_count,
   output logic [CNT_W-1:0]             write_count
);

   localparam int LW = $clog2(ways);

   if ($clog2(sets) != INDEX_W) begin : g_bad_sets
      $error("sets does not match the address layout");
   end

   ctrl_state_t             state;
   cache_line_t [ways-1:0]  rd_q;
   cache_line_t [ways-1:0]  set_new;
   logic [ways-1:0][LW-1:0] lru_cur;
   logic [ways-1:0][LW-1:0] lru_new;

   logic          hit_any;
   logic          inv_any;
   logic          fill;
   logic          upd_lru;
   logic          wb_new;
   logic [LW-1:0] hit_way;
   logic [LW-1:0] inv_way;
   logic [LW-1:0] old_way;
   logic [LW-1:0] victim;
   logic [LW-1:0] acc_way;
   logic [LW-1:0] way_new;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Descending scan so the lowest matching index wins
   always_comb begin
      hit_any = 1'b0;
      inv_any = 1'b0;
      hit_way = '0;
      inv_way = '0;
      old_way = '0;
      lru_cur = '0;
      for (int i = ways - 1; i >= 0; i--) begin
         lru_cur[i] = rd_q[i].lru;
         if (rd_q[i].mesi != MESI_I &&
             rd_q[i].tag == instruction.address.tag) begin
            hit_any = 1'b1;
            hit_way = LW'(i);
         end
         if (rd_q[i].mesi == MESI_I) begin
            inv_any = 1'b1;
            inv_way = LW'(i);
         end
         if (rd_q[i].lru == LW'(ways - 1))
            old_way = LW'(i);
      end
      victim  = inv_any ? inv_way : old_way;
      acc_way = hit_any ? hit_way : victim;
   end

   lru_update #(
      .ways (ways),
      .LW   (LW)
   ) u_lru (
      .lru      (lru_cur),
      .way      (acc_way),
      .lru_next (lru_new)
   );

   always_comb begin
      set_new = rd_q;
      fill    = 1'b0;
      upd_lru = 1'b0;
      wb_new  = 1'b0;
      case (instruction.n)
         CMD_READ, CMD_IFETCH: begin
            upd_lru = 1'b1;
            if (!hit_any) begin
               fill                 = 1'b1;
               set_new[victim].tag  = instruction.address.tag;
               set_new[victim].mesi = MESI_E;
            end
         end
         CMD_WRITE: begin
            upd_lru = 1'b1;
            if (hit_any) begin
               set_new[hit_way].mesi = MESI_M;
            end else begin
               fill                 = 1'b1;
               set_new[victim].tag  = instruction.address.tag;
               set_new[victim].mesi = MESI_M;
            end
         end
         CMD_SNP_INV: begin
            if (hit_any)
               set_new[hit_way].mesi = MESI_I;
         end
         CMD_SNP_RD: begin
            if (hit_any && (rd_q[hit_way].mesi == MESI_M ||
                            rd_q[hit_way].mesi == MESI_E)) begin
               set_new[hit_way].mesi = MESI_S;
               wb_new = rd_q[hit_way].mesi == MESI_M;
            end
         end
         default: ;
      endcase
      if (fill && rd_q[victim].mesi == MESI_M)
         wb_new = 1'b1;
      if (upd_lru) begin
         for (int i = 0; i < ways; i++)
            set_new[i].lru = lru_new[i];
      end
      way_new = hit_any ? hit_way : (fill ? victim : '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cmd_ready    <= 1'b1;
         instruction  <= '0;
         read_enable  <= 1'b0;
         write_enable <= 1'b0;
         done         <= 1'b0;
         hit          <= 1'b0;
         writeback    <= 1'b0;
         way_out      <= '0;
         rd_q         <= '0;
         cache_wr     <= '0;
         hit_count    <= '0;
         miss_count   <= '0;
         read_count   <= '0;
         write_count  <= '0;
      end else begin
         read_enable  <= 1'b0;
         write_enable <= 1'b0;
         done         <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  instruction <= cmd;
                  cmd_ready   <= 1'b0;
                  hit         <= 1'b0;
                  writeback   <= 1'b0;
                  way_out     <= '0;
                  if (uses_cmp(cmd.n) || cmd.n == CMD_PRINT) begin
                     state       <= ST_RD;
                     read_enable <= 1'b1;
                  end else if (cmd.n == CMD_RESET) begin
                     state        <= ST_WR;
                     write_enable <= 1'b1;
                  end else begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                  end
               end
            end
            ST_RD: begin
               rd_q <= cache_rd;
               if (instruction.n == CMD_PRINT) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end else begin
                  state <= ST_CMP;
               end
            end
            ST_CMP: begin
               cache_wr     <= set_new;
               hit          <= hit_any;
               writeback    <= wb_new;
               way_out      <= way_new;
               state        <= ST_WR;
               write_enable <= 1'b1;
            end
            ST_WR: begin
               state <= ST_DONE;
               done  <= 1'b1;
               if (instruction.n == CMD_RESET) begin
                  hit_count   <= '0;
                  miss_count  <= '0;
                  read_count  <= '0;
                  write_count <= '0;
               end else if (is_access(instruction.n)) begin
                  if (hit)
                     hit_count <= sat_inc(hit_count);
                  else
                     miss_count <= sat_inc(miss_count);
                  if (instruction.n == CMD_WRITE)
                     write_count <= sat_inc(write_count);
                  else
                     read_count <= sat_inc(read_count);
               end
            end
            ST_DONE: begin
               state     <= ST_IDLE;
               cmd_ready <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               cmd_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a small behavioural cache
// array (16 sets, reset LRU = ways-1-way) driving cache_rd.
module tb_cache_controller;
   import cache_controller_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cmd_valid = 1'b0;
   logic cmd_ready;
   command_t cmd = '0;
   command_t instruction;
   logic read_enable, write_enable;
   cache_line_t [WAYS-1:0] cache_rd;
   cache_line_t [WAYS-1:0] cache_wr;
   logic done, hit, writeback;
   logic [LRU_W-1:0] way_out;
   logic [31:0] hit_count, miss_count, read_count, write_count;

   cache_line_t [WAYS-1:0] mem [16];

   int vectors = 0;
   int errors = 0;
   int lat, n_re, n_we;

   always #5 clk = ~clk;

   cache_controller dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd          (cmd),
      .instruction  (instruction),
      .read_enable  (read_enable),
      .write_enable (write_enable),
      .cache_rd     (cache_rd),
      .cache_wr     (cache_wr),
      .done         (done),
      .hit          (hit),
      .writeback    (writeback),
      .way_out      (way_out),
      .hit_count    (hit_count),
      .miss_count   (miss_count),
      .read_count   (read_count),
      .write_count  (write_count)
   );

   assign cache_rd = mem[instruction.address.set_index[3:0]];

   always @(posedge clk) begin
      if (write_enable) begin
         if (instruction.n == CMD_RESET) begin
            for (int s = 0; s < 16; s++)
               for (int w = 0; w < WAYS; w++) begin
                  mem[s][w].tag  <= '0;
                  mem[s][w].mesi <= MESI_I;
                  mem[s][w].lru  <= LRU_W'(WAYS - 1 - w);
                  mem[s][w].data <= '0;
               end
         end else begin
            mem[instruction.address.set_index[3:0]] <= cache_wr;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic issue(input logic [3:0] n, input logic [TAG_W-1:0] tag,
                        input logic [INDEX_W-1:0] idx);
      int k;
      k = 0;
      @(negedge clk);
      while (!cmd_ready && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk("ready", 64'(cmd_ready), 1);
      cmd.n = n;
      cmd.address.tag = tag;
      cmd.address.set_index = idx;
      cmd.address.offset = '0;
      cmd_valid = 1'b1;
      n_re = 0;
      n_we = 0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      lat = 1;
      while (1) begin
         if (read_enable) n_re++;
         if (write_enable) n_we++;
         if (done || lat >= 20) break;
         @(posedge clk);
         #1;
         lat++;
      end
      chk("done_seen", 64'(done), 1);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 64'(cmd_ready), 1);
      chk("rst_done", 64'(done), 0);
      chk("rst_re_we", {read_enable, write_enable}, 0);
      chk("rst_cnt", 64'(hit_count | miss_count | read_count | write_count), 0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(CMD_RESET, '0, 14'd0);
      chk("clr_lat", lat, 2);
      chk("clr_we", n_we, 1);
      chk("clr_re", n_re, 0);
      chk("clr_cnt", 64'(hit_count | miss_count | read_count | write_count), 0);

      issue(CMD_READ, 12'h123, 14'd5);
      chk("rd_lat", lat, 4);
      chk("rd_re_we", {n_re[7:0], n_we[7:0]}, 16'h0101);
      chk("rd_hit", 64'(hit), 0);
      chk("rd_wb", 64'(writeback), 0);
      chk("rd_way", 64'(way_out), 0);
      chk("rd_w0", {mem[5][0].tag, 2'(mem[5][0].mesi), mem[5][0].lru},
          {12'h123, 2'(MESI_E), 3'd0});
      chk("rd_w1_lru", 64'(mem[5][1].lru), 7);
      chk("rd_w7_lru", 64'(mem[5][7].lru), 1);
      chk("rd_miss", miss_count, 1);
      chk("rd_reads", read_count, 1);

      issue(CMD_WRITE, 12'h123, 14'd5);
      chk("wr_hit", 64'(hit), 1);
      chk("wr_way", 64'(way_out), 0);
      chk("wr_mesi", 64'(mem[5][0].mesi), 64'(MESI_M));
      chk("wr_lru", {mem[5][0].lru, mem[5][1].lru, mem[5][7].lru},
          {3'd0, 3'd7, 3'd1});
      chk("wr_hits", hit_count, 1);
      chk("wr_writes", write_count, 1);

      for (int k = 1; k < 8; k++) begin
         issue(CMD_WRITE, TAG_W'(12'h200 + k), 14'd5);
         chk("fill_way", 64'(way_out), 64'(k));
      end
      chk("fill_w0_lru", 64'(mem[5][0].lru), 7);
      chk("fill_w7", {2'(mem[5][7].mesi), mem[5][7].lru},
          {2'(MESI_M), 3'd0});

      issue(CMD_READ, 12'h300, 14'd5);
      chk("ev_hit", 64'(hit), 0);
      chk("ev_wb", 64'(writeback), 1);
      chk("ev_way", 64'(way_out), 0);
      chk("ev_w0", {mem[5][0].tag, 2'(mem[5][0].mesi), mem[5][0].lru},
          {12'h300, 2'(MESI_E), 3'd0});
      chk("ev_w1_lru", 64'(mem[5][1].lru), 7);
      chk("ev_stats", {hit_count[7:0], miss_count[7:0], read_count[7:0],
                       write_count[7:0]}, 32'h01_09_02_08);

      issue(CMD_SNP_RD, 12'h201, 14'd5);
      chk("srd_hit_wb", {hit, writeback}, 2'b11);
      chk("srd_way", 64'(way_out), 1);
      chk("srd_w1", {2'(mem[5][1].mesi), mem[5][1].lru}, {2'(MESI_S), 3'd7});
      chk("srd_stats", {hit_count[7:0], miss_count[7:0]}, 16'h0109);

      issue(CMD_SNP_INV, 12'h201, 14'd5);
      chk("sinv_hit_wb", {hit, writeback}, 2'b10);
      chk("sinv_w1", 64'(mem[5][1].mesi), 64'(MESI_I));

      issue(CMD_PRINT, 12'h300, 14'd5);
      chk("prt_lat", lat, 2);
      chk("prt_re_we", {n_re[7:0], n_we[7:0]}, 16'h0100);
      chk("prt_hit", 64'(hit), 0);

      @(negedge clk);
      cmd.n = CMD_READ;
      cmd.address.tag = 12'h400;
      cmd.address.set_index = 14'd5;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("abrt_ready", 64'(cmd_ready), 1);
      chk("abrt_cnt", 64'(hit_count | miss_count | read_count | write_count), 0);
      n_we = 0;
      lat = 0;
      for (int k = 0; k < 4; k++) begin
         if (write_enable) n_we++;
         if (done) lat++;
         @(posedge clk);
         #1;
      end
      chk("abrt_we", n_we, 0);
      chk("abrt_done", lat, 0);
      chk("abrt_mem", {mem[5][0].tag, 2'(mem[5][1].mesi)},
          {12'h300, 2'(MESI_I)});

      issue(4'd7, 12'h001, 14'd3);
      chk("nop_lat", lat, 1);
      chk("nop_re_we", {n_re[7:0], n_we[7:0]}, 0);
      chk("nop_cnt", 64'(hit_count | miss_count | read_count | write_count), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
